// File: rtl/display_frame_sequencer.sv
// Frame sequencer: latches message/z operands, gathers random chunks, waits out the
// datapath latency, captures the pixel frame and streams it out row by row.
module display_frame_sequencer #(
  parameter int WIDTH   = 120,
  parameter int HEIGHT  = 52,
  parameter int RNDSIZE = 16,
  parameter int NB_SEG  = 105,
  parameter int CHUNK   = 8,
  parameter int LAT     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NB_SEG-1:0]       msg_in,
  input  logic                    z_in,
  input  logic                    rnd_valid,
  output logic                    rnd_ready,
  input  logic [CHUNK-1:0]        rnd_data,
  output logic [NB_SEG-1:0]       dp_msg,
  output logic                    dp_z,
  output logic [RNDSIZE-1:0]      dp_rnd,
  input  logic [WIDTH*HEIGHT-1:0] dp_pix,
  output logic                    row_valid,
  input  logic                    row_ready,
  output logic [WIDTH-1:0]        row_data,
  output logic [7:0]              row_idx,
  output logic                    busy,
  output logic                    frame_done,
  output logic [15:0]             frame_cnt
);

  localparam int NBEAT = RNDSIZE / CHUNK;
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int LW    = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, SEND} state_t;

  state_t                    state_q, state_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic [LW-1:0]             lat_q, lat_d;
  logic [NB_SEG-1:0]         dp_msg_q, dp_msg_d;
  logic                      dp_z_q, dp_z_d;
  logic [RNDSIZE-1:0]        dp_rnd_q, dp_rnd_d;
  logic [WIDTH*HEIGHT-1:0]   frame_q, frame_d;
  logic                      rnd_ready_q, rnd_ready_d;
  logic                      row_valid_q, row_valid_d;
  logic [WIDTH-1:0]          row_data_q, row_data_d;
  logic [7:0]                row_idx_q, row_idx_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;
  logic [15:0]               frame_cnt_q, frame_cnt_d;

  // All outputs are registered and updated together with the state they belong to,
  // so ready/valid never depend combinationally on the opposite handshake.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    lat_d        = lat_q;
    dp_msg_d     = dp_msg_q;
    dp_z_d       = dp_z_q;
    dp_rnd_d     = dp_rnd_q;
    frame_d      = frame_q;
    rnd_ready_d  = rnd_ready_q;
    row_valid_d  = row_valid_q;
    row_data_d   = row_data_q;
    row_idx_d    = row_idx_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    if (state_q != IDLE && abort) begin
      state_d     = IDLE;
      dp_rnd_d    = '0;
      rnd_ready_d = 1'b0;
      row_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = LOAD;
            dp_msg_d    = msg_in;
            dp_z_d      = z_in;
            beat_d      = '0;
            rnd_ready_d = 1'b1;
            busy_d      = 1'b1;
          end
        end
        LOAD: begin
          if (rnd_valid) begin
            dp_rnd_d[int'(beat_q)*CHUNK +: CHUNK] = rnd_data;
            if (int'(beat_q) == NBEAT - 1) begin
              state_d     = EVAL;
              rnd_ready_d = 1'b0;
              lat_d       = '0;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        EVAL: begin
          if (int'(lat_q) == LAT - 1) begin
            state_d     = SEND;
            frame_d     = dp_pix;
            row_idx_d   = 8'd0;
            row_data_d  = dp_pix[0 +: WIDTH];
            row_valid_d = 1'b1;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        SEND: begin
          if (row_ready) begin
            if (int'(row_idx_q) == HEIGHT - 1) begin
              state_d      = IDLE;
              row_valid_d  = 1'b0;
              row_idx_d    = 8'd0;
              busy_d       = 1'b0;
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 16'd1;
            end else begin
              row_idx_d  = row_idx_q + 8'd1;
              row_data_d = frame_q[(int'(row_idx_q) + 1)*WIDTH +: WIDTH];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      lat_q        <= '0;
      dp_msg_q     <= '0;
      dp_z_q       <= 1'b0;
      dp_rnd_q     <= '0;
      frame_q      <= '0;
      rnd_ready_q  <= 1'b0;
      row_valid_q  <= 1'b0;
      row_data_q   <= '0;
      row_idx_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      lat_q        <= lat_d;
      dp_msg_q     <= dp_msg_d;
      dp_z_q       <= dp_z_d;
      dp_rnd_q     <= dp_rnd_d;
      frame_q      <= frame_d;
      rnd_ready_q  <= rnd_ready_d;
      row_valid_q  <= row_valid_d;
      row_data_q   <= row_data_d;
      row_idx_q    <= row_idx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign dp_msg     = dp_msg_q;
  assign dp_z       = dp_z_q;
  assign dp_rnd     = dp_rnd_q;
  assign rnd_ready  = rnd_ready_q;
  assign row_valid  = row_valid_q;
  assign row_data   = row_data_q;
  assign row_idx    = row_idx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Self-checking bench for display_frame_sequencer: directed and randomized frames
// checked against a frame-level reference model (operands, rows, done pulses, count).
module tb_display_frame_sequencer;

  localparam int WIDTH   = 4;
  localparam int HEIGHT  = 2;
  localparam int RNDSIZE = 8;
  localparam int NB_SEG  = 8;
  localparam int CHUNK   = 4;
  localparam int LAT     = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start, abort, z_in, rnd_valid, row_ready;
  logic [NB_SEG-1:0]       msg_in;
  logic [CHUNK-1:0]        rnd_data;
  logic [WIDTH*HEIGHT-1:0] dp_pix;
  logic                    rnd_ready, dp_z, row_valid, busy, frame_done;
  logic [NB_SEG-1:0]       dp_msg;
  logic [RNDSIZE-1:0]      dp_rnd;
  logic [WIDTH-1:0]        row_data;
  logic [7:0]              row_idx;
  logic [15:0]             frame_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt  = 16'd0;

  display_frame_sequencer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .RNDSIZE(RNDSIZE),
    .NB_SEG(NB_SEG), .CHUNK(CHUNK), .LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .msg_in(msg_in), .z_in(z_in),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .dp_msg(dp_msg), .dp_z(dp_z), .dp_rnd(dp_rnd), .dp_pix(dp_pix),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rnd_ready"}, 32'(rnd_ready), 0);
    check({tag, "_row_valid"}, 32'(row_valid), 0);
    check({tag, "_row_data"}, 32'(row_data), 0);
    check({tag, "_row_idx"}, 32'(row_idx), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    check({tag, "_dp_msg"}, 32'(dp_msg), 0);
    check({tag, "_dp_z"}, 32'(dp_z), 0);
    check({tag, "_dp_rnd"}, 32'(dp_rnd), 0);
  endtask

  // One frame through the model: operands held, rnd assembled low chunk first,
  // rows are consecutive WIDTH-bit slices of the pixel word, count increments on completion.
  task automatic run_frame(input logic [NB_SEG-1:0] msg, input logic z,
                           input logic [RNDSIZE-1:0] rnd, input logic [WIDTH*HEIGHT-1:0] pix,
                           input int gap_pct, input bit fixed_gaps, input int bp_hold,
                           input int bp_pct, input int abort_row, input bit reset_eval);
    int beats, cyc, held;
    bit done;
    dp_pix = pix; msg_in = msg; z_in = z; start = 1'b1;
    tick();
    start = 1'b0;
    check("load_busy", 32'(busy), 1);
    check("load_ready", 32'(rnd_ready), 1);
    check("dp_msg", 32'(dp_msg), 32'(msg));
    check("dp_z", 32'(dp_z), 32'(z));

    beats = 0; cyc = 0;
    while (beats < RNDSIZE/CHUNK && cyc < 100) begin
      rnd_valid = fixed_gaps ? (cyc == 0 || cyc == 3) : ($urandom_range(99) >= gap_pct);
      rnd_data  = rnd_valid ? rnd[beats*CHUNK +: CHUNK] : CHUNK'($urandom);
      check("rnd_ready_load", 32'(rnd_ready), 1);
      tick();
      if (rnd_valid) beats++;
      cyc++;
    end
    rnd_valid = 1'b0;
    if (beats < RNDSIZE/CHUNK) begin
      check("rnd_timeout", 0, 1);
      return;
    end
    if (fixed_gaps) check("gap_cycles", 32'(cyc), 4);
    check("eval_rnd_ready", 32'(rnd_ready), 0);
    check("eval_busy", 32'(busy), 1);
    check("eval_row_valid", 32'(row_valid), 0);
    check("eval_dp_rnd", 32'(dp_rnd), 32'(rnd));

    if (reset_eval) begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      exp_cnt = 16'd0;
      #2 rst_n = 1'b1;
      tick();
      return;
    end

    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      check("eval_hold_valid", 32'(row_valid), 0);
      check("eval_hold_rnd", 32'(dp_rnd), 32'(rnd));
    end
    tick();

    for (int r = 0; r < HEIGHT; r++) begin
      held = 0; done = 1'b0; cyc = 0;
      while (!done && cyc < 100) begin
        if (abort_row == r) begin
          abort = 1'b1; row_ready = 1'b1;
          tick();
          abort = 1'b0; row_ready = 1'b0;
          check("abort_busy", 32'(busy), 0);
          check("abort_row_valid", 32'(row_valid), 0);
          check("abort_done", 32'(frame_done), 0);
          check("abort_cnt", 32'(frame_cnt), 32'(exp_cnt));
          check("abort_dp_rnd", 32'(dp_rnd), 0);
          tick();
          check("abort_done_after", 32'(frame_done), 0);
          return;
        end
        row_ready = (r == 0 && held < bp_hold) ? 1'b0 : ($urandom_range(99) >= bp_pct);
        check("row_valid", 32'(row_valid), 1);
        check("row_idx", 32'(row_idx), 32'(r));
        check("row_data", 32'(row_data), 32'(pix[r*WIDTH +: WIDTH]));
        check("send_dp_rnd", 32'(dp_rnd), 32'(rnd));
        tick();
        if (row_ready) done = 1'b1;
        else held++;
        cyc++;
      end
      row_ready = 1'b0;
      if (!done) begin
        check("row_timeout", 0, 1);
        return;
      end
      if (r < HEIGHT - 1) check("mid_done", 32'(frame_done), 0);
    end
    exp_cnt = exp_cnt + 16'd1;
    check("frame_done", 32'(frame_done), 1);
    check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check("end_busy", 32'(busy), 0);
    check("end_row_valid", 32'(row_valid), 0);
    tick();
    check("done_pulse_end", 32'(frame_done), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; z_in = 1'b0; rnd_valid = 1'b0;
    row_ready = 1'b0; msg_in = '0; rnd_data = '0; dp_pix = '0;
    #3;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic frame, then gaps 1,0,0,1 with 5-cycle back-pressure on row 0
    run_frame('1, 1'b1, 8'hA5, 8'hC3, 0, 1'b0, 0, 0, -1, 1'b0);
    run_frame(8'h3C, 1'b0, 8'h69, 8'h5A, 0, 1'b1, 5, 0, -1, 1'b0);
    // abort at row 1 with simultaneous handshake
    run_frame(8'h81, 1'b1, 8'h42, 8'h97, 0, 1'b0, 0, 0, 1, 1'b0);
    // async reset mid-EVAL, then a clean frame
    run_frame(8'hF0, 1'b1, 8'h17, 8'hE4, 0, 1'b0, 0, 0, -1, 1'b1);
    run_frame(8'h0F, 1'b0, 8'hB2, 8'h2D, 20, 1'b0, 0, 20, -1, 1'b0);

    // counter wrap from 0xFFFF
    force dut.frame_cnt_q = 16'hFFFF;
    tick();
    tick();
    release dut.frame_cnt_q;
    tick();
    check("preload_cnt", 32'(frame_cnt), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    run_frame(8'h55, 1'b1, 8'h3E, 8'h71, 0, 1'b0, 0, 0, -1, 1'b0);

    for (int n = 0; n < 25; n++) begin
      run_frame(NB_SEG'($urandom), 1'($urandom), RNDSIZE'($urandom),
                (WIDTH*HEIGHT)'($urandom), 30, 1'b0, 0, 30,
                ($urandom_range(7) == 0) ? int'($urandom_range(HEIGHT-1)) : -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
